// File: rtl/midi_pkg.sv
// Shared MIDI parser definitions: message type codes, parser states, length lookup.
package midi_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 7;
  localparam int unsigned CHAN_W = 4;
  localparam int unsigned TYPE_W = 3;

  typedef enum logic [TYPE_W-1:0] {
    NOTE_OFF = 3'd0,
    NOTE_ON  = 3'd1,
    POLY_AT  = 3'd2,
    CC       = 3'd3,
    PROG     = 3'd4,
    CHAN_AT  = 3'd5,
    PITCH    = 3'd6
  } msg_type_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_D1 = 2'd1,
    ST_WAIT_D2 = 2'd2,
    ST_SKIP    = 2'd3
  } state_t;

  // Number of data bytes following a channel status nibble (8..E).
  function automatic logic [1:0] data_len(input logic [3:0] nib);
    data_len = (nib == 4'hC || nib == 4'hD) ? 2'd1 : 2'd2;
  endfunction

  // Message type code for a channel status nibble.
  function automatic msg_type_t type_of(input logic [3:0] nib);
    case (nib)
      4'h9:    type_of = NOTE_ON;
      4'hA:    type_of = POLY_AT;
      4'hB:    type_of = CC;
      4'hC:    type_of = PROG;
      4'hD:    type_of = CHAN_AT;
      4'hE:    type_of = PITCH;
      default: type_of = NOTE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: running status, real-time passthrough, channel masking.
module midi_parser
  import midi_pkg::*;
#(
  parameter logic [15:0] CHAN_MASK = 16'hFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  logic [BYTE_W-1:0]   in_data,
  output logic                msg_vld,
  output logic [TYPE_W-1:0]   msg_type,
  output logic [CHAN_W-1:0]   msg_chan,
  output logic [DATA_W-1:0]   msg_d1,
  output logic [DATA_W-1:0]   msg_d2,
  output logic                rt_vld,
  output logic [BYTE_W-1:0]   rt_byte,
  output logic                orphan
);

  state_t              state_q, state_n;
  logic [BYTE_W-1:0]   status_q, status_n;
  logic [DATA_W-1:0]   d1_q, d1_n;

  logic                msg_vld_n, rt_vld_n, orphan_n;
  logic [TYPE_W-1:0]   msg_type_n;
  logic [CHAN_W-1:0]   msg_chan_n;
  logic [DATA_W-1:0]   msg_d1_n, msg_d2_n;
  logic [BYTE_W-1:0]   rt_byte_n;

  logic                emit;
  logic [DATA_W-1:0]   emit_d1, emit_d2;

  // State, running status and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      status_q <= '0;
      d1_q     <= '0;
      msg_vld  <= 1'b0;
      msg_type <= '0;
      msg_chan <= '0;
      msg_d1   <= '0;
      msg_d2   <= '0;
      rt_vld   <= 1'b0;
      rt_byte  <= '0;
      orphan   <= 1'b0;
    end else begin
      state_q  <= state_n;
      status_q <= status_n;
      d1_q     <= d1_n;
      msg_vld  <= msg_vld_n;
      msg_type <= msg_type_n;
      msg_chan <= msg_chan_n;
      msg_d1   <= msg_d1_n;
      msg_d2   <= msg_d2_n;
      rt_vld   <= rt_vld_n;
      rt_byte  <= rt_byte_n;
      orphan   <= orphan_n;
    end
  end

  // Byte classification, next state and output values.
  always_comb begin
    state_n    = state_q;
    status_n   = status_q;
    d1_n       = d1_q;
    msg_vld_n  = 1'b0;
    rt_vld_n   = 1'b0;
    orphan_n   = 1'b0;
    msg_type_n = msg_type;
    msg_chan_n = msg_chan;
    msg_d1_n   = msg_d1;
    msg_d2_n   = msg_d2;
    rt_byte_n  = rt_byte;
    emit       = 1'b0;
    emit_d1    = '0;
    emit_d2    = '0;

    if (in_vld) begin
      if (in_data >= 8'hF8) begin
        // Real-time bytes interleave without disturbing the parse.
        rt_vld_n  = 1'b1;
        rt_byte_n = in_data;
      end else if (in_data[7]) begin
        d1_n = '0;
        if (in_data[7:4] == 4'hF) begin
          status_n = '0;
          state_n  = (in_data == 8'hF6 || in_data == 8'hF7) ? ST_IDLE : ST_SKIP;
        end else begin
          status_n = in_data;
          state_n  = ST_WAIT_D1;
        end
      end else begin
        case (state_q)
          ST_IDLE:    orphan_n = 1'b1;
          ST_WAIT_D1: begin
            if (data_len(status_q[7:4]) == 2'd1) begin
              emit    = 1'b1;
              emit_d1 = in_data[DATA_W-1:0];
            end else begin
              d1_n    = in_data[DATA_W-1:0];
              state_n = ST_WAIT_D2;
            end
          end
          ST_WAIT_D2: begin
            emit    = 1'b1;
            emit_d1 = d1_q;
            emit_d2 = in_data[DATA_W-1:0];
            state_n = ST_WAIT_D1;
          end
          default: ;
        endcase
      end
    end

    // Masked channels still advance the parse but produce no pulse or field update.
    if (emit && CHAN_MASK[status_q[3:0]]) begin
      msg_vld_n  = 1'b1;
      msg_chan_n = status_q[3:0];
      msg_d1_n   = emit_d1;
      msg_d2_n   = emit_d2;
      if (type_of(status_q[7:4]) == NOTE_ON && emit_d2 == '0)
        msg_type_n = NOTE_OFF;
      else
        msg_type_n = type_of(status_q[7:4]);
    end
  end

endmodule

// File: tb/tb_midi_parser.sv
// Directed self-checking bench for midi_parser (full mask and channel-0 masked copies).
module tb_midi_parser;
  import midi_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld;
  logic [7:0] in_data;

  logic       msg_vld, rt_vld, orphan;
  logic [2:0] msg_type;
  logic [3:0] msg_chan;
  logic [6:0] msg_d1, msg_d2;
  logic [7:0] rt_byte;

  logic       m_msg_vld, m_rt_vld, m_orphan;
  logic [2:0] m_msg_type;
  logic [3:0] m_msg_chan;
  logic [6:0] m_msg_d1, m_msg_d2;
  logic [7:0] m_rt_byte;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  midi_parser #(.CHAN_MASK(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data),
    .msg_vld(msg_vld), .msg_type(msg_type), .msg_chan(msg_chan),
    .msg_d1(msg_d1), .msg_d2(msg_d2), .rt_vld(rt_vld), .rt_byte(rt_byte),
    .orphan(orphan)
  );

  midi_parser #(.CHAN_MASK(16'hFFFE)) dut_m (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data),
    .msg_vld(m_msg_vld), .msg_type(m_msg_type), .msg_chan(m_msg_chan),
    .msg_d1(m_msg_d1), .msg_d2(m_msg_d2), .rt_vld(m_rt_vld), .rt_byte(m_rt_byte),
    .orphan(m_orphan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe driven on the falling edge; returns at the next falling edge,
  // where the registered result of this byte is visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_vld  = 1'b1;
    in_data = b;
    @(negedge clk);
    in_vld  = 1'b0;
    in_data = 8'h00;
  endtask

  task automatic flags(input string tag, input logic mv, input logic rv, input logic ov);
    chk({tag, ".msg_vld"}, 32'(msg_vld), 32'(mv));
    chk({tag, ".rt_vld"},  32'(rt_vld),  32'(rv));
    chk({tag, ".orphan"},  32'(orphan),  32'(ov));
  endtask

  task automatic fields(input string tag, input logic [2:0] t, input logic [3:0] c,
                        input logic [6:0] a, input logic [6:0] b);
    chk({tag, ".type"}, 32'(msg_type), 32'(t));
    chk({tag, ".chan"}, 32'(msg_chan), 32'(c));
    chk({tag, ".d1"},   32'(msg_d1),   32'(a));
    chk({tag, ".d2"},   32'(msg_d2),   32'(b));
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    flags("reset", 1'b0, 1'b0, 1'b0);
    fields("reset", 3'd0, 4'd0, 7'h00, 7'h00);
    chk("reset.rt_byte", 32'(rt_byte), 32'h0);
    rst = 1'b0;

    // 90 3C 64 -> NOTE_ON ch0 3C/64; masked copy stays silent
    send(8'h90); flags("n1_status", 1'b0, 1'b0, 1'b0);
    send(8'h3C); flags("n1_d1", 1'b0, 1'b0, 1'b0);
    send(8'h64); flags("n1_d2", 1'b1, 1'b0, 1'b0);
    fields("n1", 3'd1, 4'd0, 7'h3C, 7'h64);
    chk("mask.n1_vld", 32'(m_msg_vld), 32'h0);
    chk("mask.n1_d1_hold", 32'(m_msg_d1), 32'h0);
    @(negedge clk); chk("n1_pulse_end", 32'(msg_vld), 32'h0);

    // 93 40 7F 40 00 -> NOTE_ON then NOTE_OFF via running status
    send(8'h93); send(8'h40); send(8'h7F);
    flags("n2_on", 1'b1, 1'b0, 1'b0);
    fields("n2_on", 3'd1, 4'd3, 7'h40, 7'h7F);
    chk("mask.n2_vld", 32'(m_msg_vld), 32'h1);
    send(8'h40); flags("n2_rs_d1", 1'b0, 1'b0, 1'b0);
    fields("n2_hold", 3'd1, 4'd3, 7'h40, 7'h7F);
    send(8'h00); flags("n2_off", 1'b1, 1'b0, 1'b0);
    fields("n2_off", 3'd0, 4'd3, 7'h40, 7'h00);

    // C5 07 07 -> two PROG messages
    send(8'hC5); send(8'h07);
    flags("p1", 1'b1, 1'b0, 1'b0);
    fields("p1", 3'd4, 4'd5, 7'h07, 7'h00);
    send(8'h07);
    flags("p2", 1'b1, 1'b0, 1'b0);
    fields("p2", 3'd4, 4'd5, 7'h07, 7'h00);

    // 90 3C F8 64 -> real-time inside a message
    send(8'h90); send(8'h3C); send(8'hF8);
    flags("rt", 1'b0, 1'b1, 1'b0);
    chk("rt.byte", 32'(rt_byte), 32'hF8);
    send(8'h64);
    flags("rt_after", 1'b1, 1'b0, 1'b0);
    fields("rt_after", 3'd1, 4'd0, 7'h3C, 7'h64);

    // F0 01 02 F7 3C -> silent sysex, then orphan
    send(8'hF0); send(8'h01); flags("sx_d", 1'b0, 1'b0, 1'b0);
    send(8'h02); flags("sx_d2", 1'b0, 1'b0, 1'b0);
    send(8'hF7); send(8'h3C); flags("sx_orphan", 1'b0, 1'b0, 1'b1);

    // SKIP exited by a channel status; pitch bend
    send(8'hF0); send(8'h11); send(8'hE2); send(8'h00); send(8'h40);
    flags("pb", 1'b1, 1'b0, 1'b0);
    fields("pb", 3'd6, 4'd2, 7'h00, 7'h40);

    // F6 drops running status straight to IDLE
    send(8'hB1); send(8'hF6); send(8'h07);
    flags("f6_orphan", 1'b0, 1'b0, 1'b1);

    // 90 3C, reset, 64 -> no message, orphan
    send(8'h90); send(8'h3C);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    fields("mid_rst", 3'd0, 4'd0, 7'h00, 7'h00);
    send(8'h64); flags("mid_rst_orphan", 1'b0, 1'b0, 1'b1);

    // Reset wins over a simultaneous byte
    @(negedge clk); rst = 1'b1; in_vld = 1'b1; in_data = 8'h90;
    @(negedge clk); rst = 1'b0; in_vld = 1'b0; in_data = 8'h00;
    send(8'h3C); flags("rst_prio", 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
